// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// State encoding, header nibble and watchdog width helper.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT_DONE,
        S_HOLD
`ifdef UART_ARB_TAG_EN
        ,
        S_TAG
`endif
    } state_t;

    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    // Watchdog counter width: must hold TIMEOUT_CYCLES-1.
    function automatic int to_width(input int cycles);
        if (cycles < 2)
            return 1;
        return $clog2(cycles);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin selector.
// Searches upward from ptr+1 (mod NUM_REQ) for the first request.
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int PW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PW-1:0]      idx,
    output logic               any
);

    int c;

    // First set bit after the pointer wins; the pointer itself is checked last.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            c = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[c]) begin
                any    = 1'b1;
                idx    = PW'(c);
                gnt[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter in front of a UART transmitter.
// Define UART_ARB_TAG_EN to prefix each packet with a header byte.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TO_W           = to_width(TIMEOUT_CYCLES)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]   i_Req_Byte,
    input  logic [NUM_REQ-1:0]     i_Req_Last,
    output logic [NUM_REQ-1:0]     o_Req_Ready,
    output logic [NUM_REQ-1:0]     o_Grant,
    output logic                   o_Tx_Ready,
    output logic [7:0]             o_Tx_Byte,
    input  logic                   i_Tx_Done,
    output logic                   o_Busy,
    output logic                   o_Err
);

    localparam int PW = $clog2(NUM_REQ);

    state_t               state_q, state_n;
    logic [NUM_REQ-1:0]   grant_q, grant_n;
    logic [PW-1:0]        gidx_q, gidx_n;
    logic [PW-1:0]        ptr_q, ptr_n;
    logic [7:0]           byte_q, byte_n;
    logic                 last_q, last_n;
    logic [TO_W-1:0]      wd_q, wd_n;
    logic [NUM_REQ-1:0]   req_rdy_q, req_rdy_n;
    logic                 tx_rdy_q, tx_rdy_n;
    logic                 err_q, err_n;
    logic                 busy_q;
    logic                 abort;

    logic [NUM_REQ-1:0]   pick_gnt;
    logic [PW-1:0]        pick_idx;
    logic                 pick_any;

    logic                 valid_g;
    logic [7:0]           byte_g;
    logic                 last_g;
    logic                 wd_hit;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req (i_Req_Valid),
        .ptr (ptr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign valid_g = i_Req_Valid[gidx_q];
    assign byte_g  = i_Req_Byte[{gidx_q, 3'b000} +: 8];
    assign last_g  = i_Req_Last[gidx_q];
    assign wd_hit  = (wd_q == TO_W'(TIMEOUT_CYCLES - 1));

    // Next-state, lock bookkeeping and registered-output values.
    always_comb begin
        state_n   = state_q;
        grant_n   = grant_q;
        gidx_n    = gidx_q;
        ptr_n     = ptr_q;
        byte_n    = byte_q;
        last_n    = last_q;
        wd_n      = wd_q;
        req_rdy_n = '0;
        tx_rdy_n  = 1'b0;
        err_n     = 1'b0;
        abort     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    grant_n = pick_gnt;
                    gidx_n  = pick_idx;
`ifdef UART_ARB_TAG_EN
                    state_n  = S_TAG;
                    byte_n   = {TAG_NIBBLE, 1'b0, 3'(pick_idx)};
                    tx_rdy_n = 1'b1;
                    wd_n     = '0;
`else
                    state_n = S_LOAD;
`endif
                end
            end

            S_LOAD: begin
                wd_n = '0;
                if (valid_g) begin
                    byte_n            = byte_g;
                    last_n            = last_g;
                    req_rdy_n[gidx_q] = 1'b1;
                    tx_rdy_n          = 1'b1;
                    state_n           = S_WAIT_DONE;
                end else begin
                    state_n = S_HOLD;
                end
            end

            S_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    if (last_q) begin
                        grant_n = '0;
                        ptr_n   = gidx_q;
                        state_n = S_IDLE;
                    end else if (valid_g) begin
                        state_n = S_LOAD;
                    end else begin
                        wd_n    = '0;
                        state_n = S_HOLD;
                    end
                end else if (wd_hit) begin
                    abort = 1'b1;
                end else begin
                    wd_n = wd_q + 1'b1;
                end
            end

            S_HOLD: begin
                if (valid_g) begin
                    state_n = S_LOAD;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end else begin
                    wd_n = wd_q + 1'b1;
                end
            end

`ifdef UART_ARB_TAG_EN
            S_TAG: begin
                if (i_Tx_Done) begin
                    state_n = S_LOAD;
                end else if (wd_hit) begin
                    abort = 1'b1;
                end else begin
                    wd_n = wd_q + 1'b1;
                end
            end
`endif

            default: begin
                grant_n = '0;
                state_n = S_IDLE;
            end
        endcase

        if (abort) begin
            err_n   = 1'b1;
            grant_n = '0;
            ptr_n   = gidx_q;
            state_n = S_IDLE;
        end
    end

    // State and output registers; reset drops any in-flight byte silently.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            gidx_q    <= '0;
            ptr_q     <= PW'(NUM_REQ - 1);
            byte_q    <= 8'h00;
            last_q    <= 1'b0;
            wd_q      <= '0;
            req_rdy_q <= '0;
            tx_rdy_q  <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            grant_q   <= grant_n;
            gidx_q    <= gidx_n;
            ptr_q     <= ptr_n;
            byte_q    <= byte_n;
            last_q    <= last_n;
            wd_q      <= wd_n;
            req_rdy_q <= req_rdy_n;
            tx_rdy_q  <= tx_rdy_n;
            err_q     <= err_n;
            busy_q    <= (state_n != S_IDLE);
        end
    end

    assign o_Req_Ready = req_rdy_q;
    assign o_Grant     = grant_q;
    assign o_Tx_Ready  = tx_rdy_q;
    assign o_Tx_Byte   = byte_q;
    assign o_Busy      = busy_q;
    assign o_Err       = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NUM_REQ=4, TIMEOUT_CYCLES=64).
// Transmitter model answers i_Tx_Done 10 cycles after o_Tx_Ready.
module tb_uart_tx_arbiter;

    localparam int NR  = 4;
    localparam int LIM = 2000;

    logic            clk;
    logic            reset_n;
    logic [NR-1:0]   i_Req_Valid;
    logic [8*NR-1:0] i_Req_Byte;
    logic [NR-1:0]   i_Req_Last;
    logic [NR-1:0]   o_Req_Ready;
    logic [NR-1:0]   o_Grant;
    logic            o_Tx_Ready;
    logic [7:0]      o_Tx_Byte;
    logic            i_Tx_Done;
    logic            o_Busy;
    logic            o_Err;

    uart_tx_arbiter #(
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_Req_Valid (i_Req_Valid),
        .i_Req_Byte  (i_Req_Byte),
        .i_Req_Last  (i_Req_Last),
        .o_Req_Ready (o_Req_Ready),
        .o_Grant     (o_Grant),
        .o_Tx_Ready  (o_Tx_Ready),
        .o_Tx_Byte   (o_Tx_Byte),
        .i_Tx_Done   (i_Tx_Done),
        .o_Busy      (o_Busy),
        .o_Err       (o_Err)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [8:0] rq [NR][$];
    logic [7:0] sent [$];
    logic [NR-1:0] glog [$];
    logic [NR-1:0] gprev = '0;
    logic [NR-1:0] rdy_prev = '0;
    int rdy_cnt [NR] = '{0, 0, 0, 0};
    int tx_cnt = 0;
    int cyc = 0;
    int done_cyc = 0;
    int ready_cyc = 0;
    int err_cyc = 0;
    int err_cnt = 0;
    bit tx_auto = 1'b1;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1);
    end

    // Requesters: pop a byte one negedge after the accept pulse.
    always @(negedge clk) begin
        for (int r = 0; r < NR; r++) begin
            if (rdy_prev[r] && i_Req_Valid[r])
                void'(rq[r].pop_front());
            if (o_Req_Ready[r])
                rdy_cnt[r]++;
        end
        rdy_prev = o_Req_Ready;
        for (int r = 0; r < NR; r++) begin
            if (rq[r].size() > 0) begin
                i_Req_Valid[r]      = 1'b1;
                i_Req_Byte[r*8+:8]  = rq[r][0][7:0];
                i_Req_Last[r]       = rq[r][0][8];
            end else begin
                i_Req_Valid[r]      = 1'b0;
                i_Req_Byte[r*8+:8]  = 8'h00;
                i_Req_Last[r]       = 1'b0;
            end
        end
    end

    // Transmitter model plus logs of sent bytes, grants and errors.
    always @(negedge clk) begin
        cyc++;
        i_Tx_Done = 1'b0;
        if (!reset_n) begin
            tx_cnt = 0;
        end else if (tx_cnt > 0) begin
            tx_cnt--;
            if (tx_cnt == 0) begin
                i_Tx_Done = 1'b1;
                done_cyc  = cyc;
            end
        end
        if (o_Tx_Ready) begin
            sent.push_back(o_Tx_Byte);
            ready_cyc = cyc;
            if (tx_auto)
                tx_cnt = 10;
        end
        if (o_Err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (o_Grant != '0 && o_Grant != gprev)
            glog.push_back(o_Grant);
        gprev = o_Grant;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    function automatic bit queues_empty();
        for (int r = 0; r < NR; r++)
            if (rq[r].size() != 0)
                return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((o_Busy || !queues_empty() || tx_cnt != 0) && n < LIM);
        check(tag, 32'(n < LIM), 1);
    endtask

    task automatic clear_logs();
        sent.delete();
        glog.delete();
    endtask

    initial begin
        int n;
        bit stable;

        reset_n     = 1'b0;
        i_Req_Valid = '0;
        i_Req_Byte  = '0;
        i_Req_Last  = '0;
        i_Tx_Done   = 1'b0;
        step();
        step();
        check("rst_grant", 32'(o_Grant), 0);
        check("rst_tx_ready", 32'(o_Tx_Ready), 0);
        check("rst_tx_byte", 32'(o_Tx_Byte), 0);
        check("rst_busy", 32'(o_Busy), 0);
        check("rst_err", 32'(o_Err), 0);
        check("rst_req_ready", 32'(o_Req_Ready), 0);
        reset_n = 1'b1;
        step();

`ifdef UART_ARB_TAG_EN
        clear_logs();
        rq[2].push_back({1'b1, 8'h7E});
        wait_idle("tag_idle");
        check("tag_count", 32'(sent.size()), 2);
        check("tag_hdr", 32'(sent[0]), 'hA2);
        check("tag_data", 32'(sent[1]), 'h7E);
        check("tag_req_ready", 32'(rdy_cnt[2]), 1);
        check("tag_grant_free", 32'(o_Grant), 0);
        check("tag_busy", 32'(o_Busy), 0);
`else
        // Single byte from requester 1, with latency.
        clear_logs();
        rq[1].push_back({1'b1, 8'h55});
        n = 0;
        while (!i_Req_Valid[1] && n < 10) begin
            step();
            n++;
        end
        check("t1_valid_seen", 32'(i_Req_Valid[1]), 1);
        step();
        check("t1_grant", 32'(o_Grant), 'b0010);
        check("t1_busy", 32'(o_Busy), 1);
        check("t1_no_early_ready", 32'(o_Tx_Ready), 0);
        step();
        check("t1_tx_ready", 32'(o_Tx_Ready), 1);
        check("t1_tx_byte", 32'(o_Tx_Byte), 'h55);
        check("t1_req_ready", 32'(o_Req_Ready), 'b0010);
        step();
        check("t1_pulse_len", 32'(o_Tx_Ready), 0);
        wait_idle("t1_idle");
        check("t1_sent_count", 32'(sent.size()), 1);
        check("t1_rdy_count", 32'(rdy_cnt[1]), 1);
        check("t1_grant_free", 32'(o_Grant), 0);

        // Packet lock: req0 three bytes while req2 waits.
        clear_logs();
        rq[0].push_back({1'b0, 8'h11});
        rq[0].push_back({1'b0, 8'h22});
        rq[0].push_back({1'b1, 8'h33});
        n = 0;
        while (o_Grant != 4'b0001 && n < 20) begin
            step();
            n++;
        end
        check("t2_grant0", 32'(o_Grant), 'b0001);
        rq[2].push_back({1'b1, 8'h44});
        wait_idle("t2_idle");
        check("t2_count", 32'(sent.size()), 4);
        check("t2_b0", 32'(sent[0]), 'h11);
        check("t2_b1", 32'(sent[1]), 'h22);
        check("t2_b2", 32'(sent[2]), 'h33);
        check("t2_b3", 32'(sent[3]), 'h44);
        check("t2_glog", 32'(glog.size()), 2);
        check("t2_glog1", 32'(glog[1]), 'b0100);
        check("t2_rdy0", 32'(rdy_cnt[0]), 3);

        // Reset while a byte is in flight.
        clear_logs();
        rq[1].push_back({1'b1, 8'h66});
        n = 0;
        while (!o_Tx_Ready && n < 20) begin
            step();
            n++;
        end
        check("t3_tx_ready", 32'(o_Tx_Ready), 1);
        step();
        reset_n = 1'b0;
        step();
        check("t3_grant", 32'(o_Grant), 0);
        check("t3_tx_ready_rst", 32'(o_Tx_Ready), 0);
        check("t3_tx_byte", 32'(o_Tx_Byte), 0);
        check("t3_busy", 32'(o_Busy), 0);
        check("t3_err", 32'(o_Err), 0);
        check("t3_req_ready", 32'(o_Req_Ready), 0);
        reset_n = 1'b1;
        step();
        check("t3_no_err", 32'(err_cnt), 0);

        // Fairness after reset: order 0,1,2,3,0.
        clear_logs();
        rq[0].push_back({1'b1, 8'hA0});
        rq[0].push_back({1'b1, 8'hB0});
        rq[1].push_back({1'b1, 8'hA1});
        rq[2].push_back({1'b1, 8'hA2});
        rq[3].push_back({1'b1, 8'hA3});
        wait_idle("t4_idle");
        check("t4_glog_n", 32'(glog.size()), 5);
        check("t4_g0", 32'(glog[0]), 'b0001);
        check("t4_g1", 32'(glog[1]), 'b0010);
        check("t4_g2", 32'(glog[2]), 'b0100);
        check("t4_g3", 32'(glog[3]), 'b1000);
        check("t4_g4", 32'(glog[4]), 'b0001);
        check("t4_sent_n", 32'(sent.size()), 5);
        check("t4_s0", 32'(sent[0]), 'hA0);
        check("t4_s3", 32'(sent[3]), 'hA3);
        check("t4_s4", 32'(sent[4]), 'hB0);

        // Requester 3 stalls mid-packet; HOLD times out.
        clear_logs();
        rq[3].push_back({1'b0, 8'hC3});
        rq[0].push_back({1'b1, 8'hD0});
        n = 0;
        while (!o_Err && n < 300) begin
            step();
            n++;
        end
        check("t5_err", 32'(o_Err), 1);
        check("t5_err_grant", 32'(o_Grant), 0);
        check("t5_err_time", 32'(err_cyc - done_cyc), 65);
        step();
        check("t5_err_pulse", 32'(o_Err), 0);
        check("t5_next_grant", 32'(o_Grant), 'b0001);
        wait_idle("t5_idle");
        check("t5_glog0", 32'(glog[0]), 'b1000);
        check("t5_glog_n", 32'(glog.size()), 2);
        check("t5_sent1", 32'(sent[1]), 'hD0);
        check("t5_err_cnt", 32'(err_cnt), 1);

        // Transmitter never answers; WAIT_DONE times out.
        clear_logs();
        tx_auto = 1'b0;
        rq[1].push_back({1'b1, 8'hE1});
        n = 0;
        while (!o_Tx_Ready && n < 20) begin
            step();
            n++;
        end
        check("t6_tx_ready", 32'(o_Tx_Ready), 1);
        stable = 1'b1;
        n = 0;
        while (!o_Err && n < 300) begin
            if (o_Tx_Byte != 8'hE1)
                stable = 1'b0;
            step();
            n++;
        end
        check("t6_err", 32'(o_Err), 1);
        check("t6_byte_stable", 32'(stable), 1);
        check("t6_err_time", 32'(err_cyc - ready_cyc), 64);
        check("t6_grant", 32'(o_Grant), 0);
        check("t6_busy", 32'(o_Busy), 0);
        check("t6_err_cnt", 32'(err_cnt), 2);
        tx_auto = 1'b1;
        wait_idle("t6_idle");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
